// File: rtl/md_scheduler.sv
// -----------------------------------------------------------------------------
// md_scheduler
//   Multi-cycle multiply/divide unit for the E stage. Accepts one
//   mult/multu/div/divu per issue and computes the 64-bit result at issue.
//   It then counts down a fixed latency and commits the result to HI/LO.
//   The unit also serves mthi/mtlo/mfhi/mflo, and it raises a D-stage stall
//   request while an md-class instruction would collide with the busy unit.
//
// Ports
//   clk       in   1   rising-edge clock
//   reset     in   1   synchronous active-low reset
//   MDOp      in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 mfhi,8 mflo
//   A         in  32   rs operand (forwarded)
//   B         in  32   rt operand (forwarded)
//   D_md      in   1   D-stage instruction is md-class
//   start     out  1   issue accepted this cycle (comb)
//   busy      out  1   countdown in progress (registered)
//   HI        out 32   HI register
//   LO        out 32   LO register
//   MDOut     out 32   HI for mfhi, otherwise LO (comb)
//   stall_md  out  1   D_md & (start | busy) (comb)
// -----------------------------------------------------------------------------
module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_md,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut,
  output logic        stall_md
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Signed 32x32 product: sign-extend both operands to 64 bits so that the
  // low 64 bits of an unsigned multiply give the two's-complement product.
  function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {{32{a[31]}}, a};
    bx = {{32{b[31]}}, b};
    return ax * bx;
  endfunction

  // Unsigned 32x32 product.
  function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {32'd0, a};
    bx = {32'd0, b};
    return ax * bx;
  endfunction

  // Unsigned divide, packed as {rem, quot}. The caller keeps b non-zero.
  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    q = a / b;
    r = a % b;
    return {r, q};
  endfunction

  // Signed divide on magnitudes, packed as {rem, quot}: the quotient
  // truncates toward zero and the remainder follows the sign of a.
  // 0x80000000 / -1 works without a special case: its magnitude 0x80000000
  // divided by 1 negates back to 0x80000000, and the remainder is 0.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q;
    logic [31:0] r;
    mag_a = a[31] ? (32'd0 - a) : a;
    mag_b = b[31] ? (32'd0 - b) : b;
    uq    = mag_a / mag_b;
    ur    = mag_a % mag_b;
    q     = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
    r     = a[31] ? (32'd0 - ur) : ur;
    return {r, q};
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic             pend_ok_q, pend_ok_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        is_mul_s;
  logic        is_div_s;
  logic        div_zero_s;
  logic [31:0] div_b_s;
  logic [63:0] result_s;
  logic        start_s;

  assign is_mul_s   = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
  assign is_div_s   = (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
  assign div_zero_s = (B == 32'd0);
  // A zero divisor is replaced with 1 so the divider never sees 0.
  // The resulting value is discarded at commit.
  assign div_b_s    = div_zero_s ? 32'd1 : B;

  // Full 64-bit result for the op in E, formed from the forwarded operands.
  always_comb begin
    result_s = 64'd0;
    case (MDOp)
      OP_MULT:  result_s = mul_signed(A, B);
      OP_MULTU: result_s = mul_unsigned(A, B);
      OP_DIV:   result_s = div_signed(A, div_b_s);
      OP_DIVU:  result_s = div_unsigned(A, div_b_s);
      default:  result_s = 64'd0;
    endcase
  end

  // Scheduler next state: issue, countdown, commit and HI/LO moves.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_ok_d = pend_ok_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    start_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_mul_s || is_div_s) begin
          start_s   = 1'b1;
          state_d   = ST_RUN;
          cnt_d     = is_mul_s ? MULT_LAT : DIV_LAT;
          pend_d    = result_s;
          pend_ok_d = !(is_div_s && div_zero_s);
        end else if (MDOp == OP_MTHI) begin
          hi_d = A;
        end else if (MDOp == OP_MTLO) begin
          lo_d = A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Any op arriving here is ignored. Correct stalling keeps MDOp at 0.
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          if (pend_ok_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State registers. A synchronous reset also drops any pending result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      pend_q    <= 64'd0;
      pend_ok_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_ok_q <= pend_ok_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign start    = start_s;
  assign busy     = (cnt_q != CNT_ZERO);
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign MDOut    = (MDOp == OP_MFHI) ? hi_q : lo_q;
  assign stall_md = D_md & (start_s | busy);

endmodule

// File: tb/tb_md_scheduler.sv
// -----------------------------------------------------------------------------
// tb_md_scheduler
//   Scoreboard bench for md_scheduler. The bench computes an expected HI/LO
//   result from its own arithmetic model and pushes it when an op is issued.
//   It pops and compares that result when busy falls.
// -----------------------------------------------------------------------------
module tb_md_scheduler;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        D_md;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDOut;
  logic        stall_md;

  md_scheduler #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .MDOp     (MDOp),
    .A        (A),
    .B        (B),
    .D_md     (D_md),
    .start    (start),
    .busy     (busy),
    .HI       (HI),
    .LO       (LO),
    .MDOut    (MDOut),
    .stall_md (stall_md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] sb_q[$];
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {HI, LO} expected after the op commits.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    longint sp;
    longint unsigned ua;
    longint unsigned ub;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: begin
        sp = longint'(sa) * longint'(sb);
        return sp;
      end
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 32'd0) return {hi_m, lo_m};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      4'd4: begin
        if (b == 32'd0) return {hi_m, lo_m};
        return {a % b, a / b};
      end
      default: return {hi_m, lo_m};
    endcase
  endfunction

  // Issue one mult/div, check start/busy/stall each cycle, then score HI/LO.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic dmd, input logic intrude);
    int lat;
    int ncyc;
    logic [63:0] e;
    lat = (op <= 4'd2) ? MULT_LAT : DIV_LAT;
    @(posedge clk); #1;
    sb_q.push_back(model(op, a, b));
    MDOp = op; A = a; B = b; D_md = dmd;
    @(negedge clk);
    check_val("start", {63'd0, start}, 64'd1);
    check_val("stall_start", {63'd0, stall_md}, {63'd0, dmd});
    @(posedge clk); #1;
    MDOp = 4'd0; A = $urandom; B = $urandom;
    ncyc = 0;
    @(negedge clk);
    while (busy === 1'b1 && ncyc < 50) begin
      ncyc++;
      check_val("stall_busy", {63'd0, stall_md}, {63'd0, dmd});
      if (intrude && ncyc == 2) begin
        MDOp = 4'd5; A = 32'hDEAD_BEEF;
        #1;
        check_val("start_when_busy", {63'd0, start}, 64'd0);
      end
      @(posedge clk); #1;
      MDOp = 4'd0;
      @(negedge clk);
    end
    check_val("busy_cycles", 64'(ncyc), 64'(lat));
    check_val("stall_idle", {63'd0, stall_md}, 64'd0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("HI", {32'd0, HI}, {32'd0, e[63:32]});
      check_val("LO", {32'd0, LO}, {32'd0, e[31:0]});
      hi_m = e[63:32];
      lo_m = e[31:0];
    end else begin
      check_val("scoreboard_empty", 64'd1, 64'd0);
    end
    D_md = 1'b0;
  endtask

  // mthi/mtlo followed by mfhi/mflo readback.
  task automatic do_move(input logic hi_sel, input logic [31:0] v);
    @(posedge clk); #1;
    MDOp = hi_sel ? 4'd5 : 4'd6; A = v;
    #1;
    check_val("mt_no_start", {63'd0, start}, 64'd0);
    if (hi_sel) hi_m = v; else lo_m = v;
    @(posedge clk); #1;
    MDOp = 4'd7;
    #1;
    check_val("mfhi", {32'd0, MDOut}, {32'd0, hi_m});
    check_val("mt_no_busy", {63'd0, busy}, 64'd0);
    MDOp = 4'd8;
    #1;
    check_val("mflo", {32'd0, MDOut}, {32'd0, lo_m});
    MDOp = 4'd0;
  endtask

  initial begin
    reset = 1'b0; MDOp = 4'd0; A = 32'd0; B = 32'd0; D_md = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_val("rst_HI", {32'd0, HI}, 64'd0);
    check_val("rst_LO", {32'd0, LO}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_start", {63'd0, start}, 64'd0);
    check_val("rst_stall", {63'd0, stall_md}, 64'd0);

    do_op(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
    do_op(4'd4, 32'd7, 32'd2, 1'b0, 1'b0);
    do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    do_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);

    do_move(1'b1, 32'h1234_5678);
    do_move(1'b0, 32'h9ABC_DEF0);
    do_op(4'd3, 32'd99, 32'd0, 1'b1, 1'b0);
    do_op(4'd4, 32'd99, 32'd0, 1'b0, 1'b0);

    // Reset in the middle of a mult: no late commit, then a clean restart.
    @(posedge clk); #1;
    MDOp = 4'd1; A = 32'd1000; B = 32'd1000;
    @(posedge clk); #1;
    MDOp = 4'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    hi_m = 32'd0; lo_m = 32'd0;
    check_val("midrst_busy", {63'd0, busy}, 64'd0);
    check_val("midrst_HI", {32'd0, HI}, 64'd0);
    check_val("midrst_LO", {32'd0, LO}, 64'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_val("no_late_HI", {32'd0, HI}, 64'd0);
    check_val("no_late_LO", {32'd0, LO}, 64'd0);
    do_op(4'd1, 32'h0001_0000, 32'h0003_0000, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      do_op(4'($urandom_range(1, 4)), ra, rb, i[0], 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
